// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared SPI types and SCLK edge-select helpers (slave and master).
// Revision : 1.0
// ============================================================================
package spi_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    localparam int   c_BIT_CNT_W     = 5;
    localparam logic c_SYNC_RST_CS   = 1'b1;
    localparam logic c_SYNC_RST_DATA = 1'b0;

    // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
    function automatic logic sample_on_rising(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_input_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_input_sync
// Brief    : Multi-bit, multi-stage flop synchronizer with per-bit reset value.
// Revision : 1.0
// ============================================================================
module spi_input_sync #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Brief    : SPI slave, modes 0-3, MSB first, oversampled by the system clock.
//            Define SPI_SLAVE_UNDERRUN_FLAG_EN to add the o_tx_underrun output.
// Revision : 1.0
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_DATA_WIDTH = 32,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_clock_polarity,
    input  logic                      i_clock_phase,
    input  logic [SPI_DATA_WIDTH-1:0] i_data_in,
    input  logic                      i_data_load,
    output logic [SPI_DATA_WIDTH-1:0] o_data_out,
    output logic                      o_data_valid,
    output logic                      o_busy,
    input  logic                      i_spi_cs_n,
    input  logic                      i_spi_clock,
    input  logic                      i_spi_mosi,
    output logic                      o_spi_miso,
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    output logic                      o_spi_miso_oe,
    output logic                      o_tx_underrun
`else
    output logic                      o_spi_miso_oe
`endif
);

    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT = c_BIT_CNT_W'(SPI_DATA_WIDTH - 1);

    logic [2:0] w_sync;
    logic       w_cs_s;
    logic       w_sclk_s;
    logic       w_mosi_s;

    spi_input_sync #(
        .WIDTH     (3),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL ({c_SYNC_RST_CS, c_SYNC_RST_DATA, c_SYNC_RST_DATA})
    ) u_sync (
        .clk   (i_clock),
        .rst_n (i_reset_n),
        .i_d   ({i_spi_cs_n, i_spi_clock, i_spi_mosi}),
        .o_q   (w_sync)
    );

    assign {w_cs_s, w_sclk_s, w_mosi_s} = w_sync;

    spi_state_t                r_state;
    spi_state_t                w_state_next;
    logic                      r_sclk_prev;
    logic                      r_cs_prev;
    logic [SYNC_STAGES-1:0]    r_settle;
    logic                      r_armed;
    logic                      r_cpol;
    logic                      r_cpha;
    logic [SPI_DATA_WIDTH-1:0] r_tx_hold;
    logic [SPI_DATA_WIDTH-1:0] r_tx_shift;
    logic [SPI_DATA_WIDTH-1:0] r_rx_shift;
    logic [c_BIT_CNT_W-1:0]    r_bit_cnt;
    logic                      r_word_done;
    logic [SPI_DATA_WIDTH-1:0] r_data_out;
    logic                      r_data_valid;

    logic w_rise;
    logic w_fall;
    logic w_samp_rising;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_start;
    logic w_stop;
    logic w_sample;
    logic w_shift;
    logic w_word_end;
    logic w_reload;
    logic [SPI_DATA_WIDTH-1:0] w_reload_val;

    assign w_rise        = w_sclk_s & ~r_sclk_prev;
    assign w_fall        = ~w_sclk_s & r_sclk_prev;
    assign w_samp_rising = sample_on_rising(r_cpol, r_cpha);
    // A falling cs_n only counts once cs_n has been seen high after reset.
    assign w_cs_fall     = r_armed & r_cs_prev & ~w_cs_s;
    assign w_cs_rise     = ~r_cs_prev & w_cs_s;

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_stop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_ACTIVE;
                    w_start      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                    w_stop       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_sample   = (r_state == ST_ACTIVE) & (w_samp_rising ? w_rise : w_fall);
    // The shift edge following the last sample of a word is skipped so the
    // freshly reloaded MSB stays on MISO.
    assign w_shift    = (r_state == ST_ACTIVE) & (w_samp_rising ? w_fall : w_rise)
                        & (r_bit_cnt != '0);
    assign w_word_end = w_sample & (r_bit_cnt == c_LAST_BIT);
    assign w_reload   = w_start | w_word_end;
    assign w_reload_val = i_data_load ? i_data_in : r_tx_hold;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sclk_prev  <= 1'b0;
            r_cs_prev    <= 1'b1;
            r_settle     <= '0;
            r_armed      <= 1'b0;
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_tx_hold    <= '0;
            r_tx_shift   <= '0;
            r_rx_shift   <= '0;
            r_bit_cnt    <= '0;
            r_word_done  <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_sclk_prev  <= w_sclk_s;
            r_cs_prev    <= w_cs_s;
            r_settle     <= {r_settle[SYNC_STAGES-2:0], 1'b1};
            r_word_done  <= 1'b0;
            r_data_valid <= 1'b0;

            if (r_settle[SYNC_STAGES-1] && w_cs_s) begin
                r_armed <= 1'b1;
            end

            if (r_state == ST_IDLE) begin
                r_cpol <= i_clock_polarity;
                r_cpha <= i_clock_phase;
            end

            if (i_data_load) begin
                r_tx_hold <= i_data_in;
            end

            if (r_word_done) begin
                r_data_out   <= r_rx_shift;
                r_data_valid <= 1'b1;
            end

            if (w_stop) begin
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
            end else if (w_sample) begin
                r_rx_shift  <= {r_rx_shift[SPI_DATA_WIDTH-2:0], w_mosi_s};
                r_bit_cnt   <= w_word_end ? '0 : r_bit_cnt + 1'b1;
                r_word_done <= w_word_end;
            end

            if (w_reload) begin
                r_tx_shift <= w_reload_val;
            end else if (w_shift) begin
                r_tx_shift <= {r_tx_shift[SPI_DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    logic r_loaded;
    logic r_tx_underrun;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_loaded      <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            if (w_reload) begin
                r_loaded <= 1'b0;
                if (w_word_end && !i_data_load && !r_loaded) begin
                    r_tx_underrun <= 1'b1;
                end
            end else if (i_data_load) begin
                r_loaded <= 1'b1;
            end
            if (i_data_load) begin
                r_tx_underrun <= 1'b0;
            end
        end
    end

    assign o_tx_underrun = r_tx_underrun;
`endif

    assign o_data_out    = r_data_out;
    assign o_data_valid  = r_data_valid;
    assign o_busy        = (r_state == ST_ACTIVE);
    assign o_spi_miso_oe = o_busy;
    assign o_spi_miso    = o_spi_miso_oe & r_tx_shift[SPI_DATA_WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Brief    : Self-checking bench for spi_slave: SPI master driver, queue model.
// Revision : 1.0
// ============================================================================
module tb_spi_slave;

    localparam int c_W = 32;
    localparam int c_S = 2;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b0;
    logic           cpol    = 1'b0;
    logic           cpha    = 1'b0;
    logic           load    = 1'b0;
    logic           cs_n    = 1'b1;
    logic           sclk    = 1'b0;
    logic           mosi    = 1'b0;
    logic [c_W-1:0] data_in = '0;
    logic [c_W-1:0] data_out;
    logic           valid;
    logic           busy;
    logic           miso;
    logic           miso_oe;
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
    logic           underrun;
`endif

    always #5 clk = ~clk;

    spi_slave #(.SPI_DATA_WIDTH(c_W), .SYNC_STAGES(c_S)) dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_clock_polarity (cpol),
        .i_clock_phase    (cpha),
        .i_data_in        (data_in),
        .i_data_load      (load),
        .o_data_out       (data_out),
        .o_data_valid     (valid),
        .o_busy           (busy),
        .i_spi_cs_n       (cs_n),
        .i_spi_clock      (sclk),
        .i_spi_mosi       (mosi),
        .o_spi_miso       (miso),
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
        .o_spi_miso_oe    (miso_oe),
        .o_tx_underrun    (underrun)
`else
        .o_spi_miso_oe    (miso_oe)
`endif
    );

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int vcount = 0;

    typedef struct { int due; logic [c_W-1:0] d; } vev_t;
    typedef struct { int due; logic v; } bev_t;
    vev_t vq[$];
    bev_t bq[$];

    // Model state: last word delivered, chip-select view, TX holding value.
    logic [c_W-1:0] m_out  = '0;
    logic [c_W-1:0] m_hold = '0;
    logic           m_busy = 1'b0;

    logic [c_W-1:0] tx_mosi  [5];
    logic [c_W-1:0] ld_val   [5];
    logic [c_W-1:0] cap_miso [5];
    logic [c_W-1:0] exp_miso [5];
    bit             ld_en    [5];

    task automatic check(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (!rst_n) begin
                vq.delete();
                bq.delete();
                m_out  = '0;
                m_busy = 1'b0;
                check("reset_valid", {31'd0, valid}, 32'd0);
            end else begin
                while (bq.size() > 0 && bq[0].due <= cyc) begin
                    m_busy = bq[0].v;
                    void'(bq.pop_front());
                end
                if (vq.size() > 0 && vq[0].due == cyc) begin
                    check("valid_pulse", {31'd0, valid}, 32'd1);
                    m_out = vq[0].d;
                    void'(vq.pop_front());
                end else begin
                    check("valid_quiet", {31'd0, valid}, 32'd0);
                end
            end
            if (valid === 1'b1) vcount++;
            check("data_out", data_out, m_out);
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("miso_oe", {31'd0, miso_oe}, {31'd0, m_busy});
            if (!m_busy) check("miso_idle", {31'd0, miso}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [c_W-1:0] v);
        tick();
        data_in = v;
        load    = 1'b1;
        m_hold  = v;
        tick();
        load    = 1'b0;
    endtask

    task automatic half_wait(input int hp, input bit do_ld, input logic [c_W-1:0] v);
        for (int i = 0; i < hp; i++) begin
            tick();
            if (i == 0 && do_ld) begin
                data_in = v;
                load    = 1'b1;
                m_hold  = v;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
    endtask

    // Master side: nw words, optional stop after stop_bits samples, optional reset there.
    task automatic xfer(input bit pol, input bit pha, input int hp, input int nw,
                        input int stop_bits, input bit do_reset);
        int  nbits = 0;
        bit  done  = 1'b0;
        bit  dl;
        tick();
        cpol = pol;
        cpha = pha;
        sclk = pol;
        repeat (2 * hp) tick();
        cs_n = 1'b0;
        bq.push_back('{cyc + c_S + 1, 1'b1});
        repeat (hp) tick();
        for (int w = 0; w < nw && !done; w++) begin
            exp_miso[w] = m_hold;
            cap_miso[w] = '0;
            for (int b = c_W - 1; b >= 0 && !done; b--) begin
                if (pha) sclk = ~pol;
                mosi = tx_mosi[w][b];
                dl = (b == c_W - 6) && (w + 1 < nw) && ld_en[w+1];
                half_wait(hp, dl, ld_val[w+1]);
                cap_miso[w][b] = miso;
                sclk = pha ? pol : ~pol;
                nbits++;
                if (b == 0) vq.push_back('{cyc + c_S + 2, tx_mosi[w]});
                half_wait(hp, 1'b0, '0);
                if (!pha) sclk = pol;
                if (stop_bits != 0 && nbits == stop_bits) done = 1'b1;
            end
        end
        repeat (hp) tick();
        if (do_reset) begin
            rst_n = 1'b0;
            #1;
            check("rst_data_out", data_out, 32'd0);
            check("rst_valid", {31'd0, valid}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_miso", {31'd0, miso}, 32'd0);
            check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
            m_hold = '0;
            repeat (3) tick();
            rst_n = 1'b1;
            repeat (4) tick();
        end
        cs_n = 1'b1;
        bq.push_back('{cyc + c_S + 1, 1'b0});
        repeat (2 * hp + c_S + 4) tick();
        if (stop_bits == 0) begin
            for (int w = 0; w < nw; w++) check("miso_word", cap_miso[w], exp_miso[w]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        for (int i = 0; i < 5; i++) begin
            ld_en[i]  = 1'b0;
            ld_val[i] = '0;
            tx_mosi[i] = '0;
        end

        repeat (3) tick();
        check("init_data_out", data_out, 32'd0);
        check("init_valid", {31'd0, valid}, 32'd0);
        check("init_busy", {31'd0, busy}, 32'd0);
        check("init_miso", {31'd0, miso}, 32'd0);
        check("init_miso_oe", {31'd0, miso_oe}, 32'd0);
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
        check("init_underrun", {31'd0, underrun}, 32'd0);
`endif
        rst_n = 1'b1;
        repeat (8) tick();

        // Mode 0 basic word
        do_load(32'hA5A5_1234);
        tx_mosi[0] = 32'hDEAD_BEEF;
        v0 = vcount;
        xfer(1'b0, 1'b0, 5, 1, 0, 1'b0);
        check("m0_rx", data_out, 32'hDEAD_BEEF);
        check("m0_pulses", vcount - v0, 32'd1);
        check("m0_miso", cap_miso[0], 32'hA5A5_1234);

        // Modes 1..3, unrefreshed holding register retransmitted
        for (int m = 1; m < 4; m++) begin
            tx_mosi[0] = 32'h8000_0001;
            v0 = vcount;
            xfer(m[1], m[0], 5, 1, 0, 1'b0);
            check("mode_rx", data_out, 32'h8000_0001);
            check("mode_pulses", vcount - v0, 32'd1);
            check("mode_miso", cap_miso[0], 32'hA5A5_1234);
        end

        // Two-word burst, one load in between
        tx_mosi[0] = 32'h1111_1111;
        tx_mosi[1] = 32'h2222_2222;
        ld_en[1]   = 1'b1;
        ld_val[1]  = 32'h0F0F_5AA5;
        v0 = vcount;
        xfer(1'b0, 1'b0, 5, 2, 0, 1'b0);
        ld_en[1] = 1'b0;
        check("burst_pulses", vcount - v0, 32'd2);
        check("burst_rx", data_out, 32'h2222_2222);
        check("burst_miso0", cap_miso[0], 32'hA5A5_1234);
        check("burst_miso1", cap_miso[1], 32'h0F0F_5AA5);
`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
        check("burst_underrun", {31'd0, underrun}, 32'd0);
`endif

        // Abort after 17 bits, then a clean transfer
        tx_mosi[0] = 32'h3C3C_3C3C;
        v0 = vcount;
        xfer(1'b1, 1'b0, 5, 1, 17, 1'b0);
        check("abort_pulses", vcount - v0, 32'd0);
        check("abort_keep", data_out, 32'h2222_2222);
        tx_mosi[0] = 32'h5A5A_0FF0;
        xfer(1'b1, 1'b0, 5, 1, 0, 1'b0);
        check("post_abort_rx", data_out, 32'h5A5A_0FF0);
        check("post_abort_miso", cap_miso[0], 32'h0F0F_5AA5);

        // Reset at bit 10, then a clean transfer
        tx_mosi[0] = 32'hFFFF_0000;
        xfer(1'b0, 1'b1, 5, 1, 10, 1'b1);
        check("after_rst_out", data_out, 32'd0);
        do_load(32'hCAFE_F00D);
        tx_mosi[0] = 32'h1357_9BDF;
        v0 = vcount;
        xfer(1'b0, 1'b1, 5, 1, 0, 1'b0);
        check("rst_next_rx", data_out, 32'h1357_9BDF);
        check("rst_next_pulses", vcount - v0, 32'd1);
        check("rst_next_miso", cap_miso[0], 32'hCAFE_F00D);

`ifdef SPI_SLAVE_UNDERRUN_FLAG_EN
        do_load(32'h600D_F00D);
        tx_mosi[0] = 32'h0000_FFFF;
        tx_mosi[1] = 32'hFFFF_0000;
        xfer(1'b0, 1'b0, 5, 2, 0, 1'b0);
        check("ur_set", {31'd0, underrun}, 32'd1);
        check("ur_retx", cap_miso[1], 32'h600D_F00D);
        do_load(32'h1234_5678);
        tick();
        check("ur_clear", {31'd0, underrun}, 32'd0);
`endif

        // Randomized transactions
        for (int it = 0; it < 12; it++) begin
            int nw;
            nw = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) do_load($urandom);
            for (int w = 0; w < 5; w++) begin
                tx_mosi[w] = $urandom;
                ld_val[w]  = $urandom;
                ld_en[w]   = ($urandom_range(0, 1) == 1);
            end
            v0 = vcount;
            xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(4, 8), nw, 0, 1'b0);
            check("rand_pulses", vcount - v0, nw);
            check("rand_rx", data_out, tx_mosi[nw-1]);
        end

        repeat (10) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
